// File: rtl/vga_draw_pkg.sv
// rtl/vga_draw_pkg.sv - shared draw-engine state encoding and screen defaults
package vga_draw_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_CLEAR = 2'd2,
    S_DONE  = 2'd3
  } draw_state_t;

  localparam int SCR_W_DEF   = 160;
  localparam int SCR_H_DEF   = 120;
  localparam int COLOR_W_DEF = 3;
  localparam int CLEAR_COLOR = 0;

endpackage

// File: rtl/vga_raster_counter.sv
// rtl/vga_raster_counter.sv - nested column/row counter with load, step and last flag
module vga_raster_counter #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           load,
  input  logic           step,
  input  logic [X_W-1:0] ext_w,
  input  logic [Y_W-1:0] ext_h,
  output logic [X_W-1:0] next_cx,
  output logic [Y_W-1:0] next_cy,
  output logic           last
);

  logic [X_W-1:0] w_r;
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] h_r;
  logic [Y_W-1:0] cy;
  logic           row_end;

  // Extents are captured on load so the caller's inputs may change afterwards.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      w_r <= '0;
      h_r <= '0;
      cx  <= '0;
      cy  <= '0;
    end else if (load) begin
      w_r <= ext_w;
      h_r <= ext_h;
      cx  <= '0;
      cy  <= '0;
    end else if (step) begin
      cx  <= next_cx;
      cy  <= next_cy;
    end
  end

  // Raster order: column wraps at W-1, then the row advances.
  always_comb begin
    row_end = (cx == w_r - X_W'(1));
    last    = row_end && (cy == h_r - Y_W'(1));
    next_cx = row_end ? '0 : cx + X_W'(1);
    next_cy = row_end ? cy + Y_W'(1) : cy;
  end

endmodule

// File: rtl/vga_rect_fill_engine.sv
// rtl/vga_rect_fill_engine.sv - rectangle fill / screen clear pixel streamer (optional clipping: VGA_RECT_CLIP_EN)
module vga_rect_fill_engine
  import vga_draw_pkg::*;
#(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = COLOR_W_DEF,
  parameter int SCR_W   = SCR_W_DEF,
  parameter int SCR_H   = SCR_H_DEF
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic               clear,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic [X_W-1:0]     rect_w,
  input  logic [Y_W-1:0]     rect_h,
  input  logic [COLOR_W-1:0] color_in,
  output logic               busy,
  output logic               done,
  output logic               plot,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic [COLOR_W-1:0] color_out
);

  localparam logic [X_W-1:0] SCR_W_X = X_W'(SCR_W);
  localparam logic [Y_W-1:0] SCR_H_Y = Y_W'(SCR_H);

  draw_state_t        state, state_d;
  logic [X_W-1:0]     ox, org_x, off_x, pix_x, next_cx, ext_w, x_d;
  logic [Y_W-1:0]     oy, org_y, off_y, pix_y, next_cy, ext_h, y_d;
  logic [COLOR_W-1:0] color_l, new_color, color_d;
  logic               accept, load, step, last, in_bounds;
  logic               busy_d, done_d, plot_d;

  assign accept    = (state == S_IDLE) && start;
  assign new_color = clear ? COLOR_W'(CLEAR_COLOR) : color_in;
  assign ext_w     = clear ? SCR_W_X : rect_w;
  assign ext_h     = clear ? SCR_H_Y : rect_h;

  // On the accept cycle the first pixel is the new origin itself, so its
  // coordinates come straight from the inputs; afterwards from the latches.
  assign org_x = accept ? (clear ? '0 : x0) : ox;
  assign org_y = accept ? (clear ? '0 : y0) : oy;
  assign off_x = accept ? '0 : next_cx;
  assign off_y = accept ? '0 : next_cy;

`ifdef VGA_RECT_CLIP_EN
  localparam logic [X_W:0] SCR_W_L = (X_W+1)'(SCR_W);
  localparam logic [Y_W:0] SCR_H_L = (Y_W+1)'(SCR_H);
  logic [X_W:0] sum_x;
  logic [Y_W:0] sum_y;
  assign sum_x     = {1'b0, org_x} + {1'b0, off_x};
  assign sum_y     = {1'b0, org_y} + {1'b0, off_y};
  assign pix_x     = sum_x[X_W-1:0];
  assign pix_y     = sum_y[Y_W-1:0];
  assign in_bounds = (sum_x < SCR_W_L) && (sum_y < SCR_H_L);
`else
  // Plain X_W-bit add is the wide sum truncated, i.e. it wraps modulo 2^X_W.
  assign pix_x     = org_x + off_x;
  assign pix_y     = org_y + off_y;
  assign in_bounds = 1'b1;
`endif

  vga_raster_counter #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_raster (
    .clock   (clock),
    .resetn  (resetn),
    .load    (load),
    .step    (step),
    .ext_w   (ext_w),
    .ext_h   (ext_h),
    .next_cx (next_cx),
    .next_cy (next_cy),
    .last    (last)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_d;
  end

  // Registered outputs, loaded from the next-value logic below.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      plot      <= 1'b0;
      x         <= '0;
      y         <= '0;
      color_out <= '0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      plot      <= plot_d;
      x         <= x_d;
      y         <= y_d;
      color_out <= color_d;
    end
  end

  // Origin and colour latched at acceptance; start while busy never reaches here.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ox      <= '0;
      oy      <= '0;
      color_l <= '0;
    end else if (load) begin
      ox      <= org_x;
      oy      <= org_y;
      color_l <= new_color;
    end
  end

  // Next state and next output values; counter tracks the pixel on the outputs.
  always_comb begin
    state_d = state;
    busy_d  = busy;
    done_d  = 1'b0;
    plot_d  = 1'b0;
    x_d     = x;
    y_d     = y;
    color_d = color_out;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          load    = 1'b1;
          busy_d  = 1'b1;
          color_d = new_color;
          if (!clear && (rect_w == '0 || rect_h == '0)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = clear ? S_CLEAR : S_FILL;
            plot_d  = in_bounds;
            x_d     = pix_x;
            y_d     = pix_y;
          end
        end
      end
      S_FILL, S_CLEAR: begin
        color_d = color_l;
        if (last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          step   = 1'b1;
          plot_d = in_bounds;
          x_d    = pix_x;
          y_d    = pix_y;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
